// File: rtl/core6_mem_block_copier.sv
// Avalon-MM master that copies a run of 32-bit words between two regions of the
// Core6 single-port on-chip RAM, one read and one write cycle per word.
module core6_mem_block_copier #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_W-1:0]     cmd_src,
    input  logic [ADDR_W-1:0]     cmd_dst,
    input  logic [ADDR_W:0]       cmd_len,
    input  logic                  hold,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_W-1:0]     mem_address,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        FIN  = 3'd3,
        ERR  = 3'd4
    } state_t;

    // A length equal to the memory depth is legal; anything above it is rejected.
    localparam logic [ADDR_W:0] MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ZERO_LEN = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0] ONE_LEN  = {{ADDR_W{1'b0}}, 1'b1};

    state_t              state_r;
    state_t              state_s;
    logic [ADDR_W-1:0]   src_r;
    logic [ADDR_W-1:0]   dst_r;
    logic [ADDR_W:0]     len_r;
    logic [ADDR_W:0]     cnt_r;
    logic [ADDR_W:0]     cnt_inc_s;
    logic                accept_s;

    assign cnt_inc_s = cnt_r + ONE_LEN;
    assign accept_s  = (state_r == IDLE) && cmd_valid;

    // Next-state decode; hold is applied at the register so this stays pure.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len > MAX_LEN) begin
                        state_s = ERR;
                    end else if (cmd_len == ZERO_LEN) begin
                        state_s = FIN;
                    end else begin
                        state_s = RD;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RD: state_s = WR;
            WR: begin
                if (cnt_inc_s == len_r) begin
                    state_s = FIN;
                end else begin
                    state_s = RD;
                end
            end
            FIN:     state_s = IDLE;
            ERR:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, command latch and word counter; everything freezes while held.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            src_r   <= {ADDR_W{1'b0}};
            dst_r   <= {ADDR_W{1'b0}};
            len_r   <= ZERO_LEN;
            cnt_r   <= ZERO_LEN;
        end else if (!hold) begin
            state_r <= state_s;
            if (accept_s) begin
                src_r <= cmd_src;
                dst_r <= cmd_dst;
                len_r <= cmd_len;
                cnt_r <= ZERO_LEN;
            end else if (state_r == WR) begin
                cnt_r <= cnt_inc_s;
            end
        end
    end

    // Memory strobes decoded from the registered state; write data is the
    // RAM output captured by the preceding read, passed straight through.
    always_comb begin
        mem_address    = {ADDR_W{1'b0}};
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_writedata  = {DATA_W{1'b0}};
        case (state_r)
            RD: begin
                mem_address    = src_r + cnt_r[ADDR_W-1:0];
                mem_chipselect = 1'b1;
            end
            WR: begin
                mem_address    = dst_r + cnt_r[ADDR_W-1:0];
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
                mem_writedata  = mem_readdata;
            end
            default: begin
                mem_address    = {ADDR_W{1'b0}};
                mem_chipselect = 1'b0;
            end
        endcase
    end

    assign mem_byteenable = {(DATA_W/8){1'b1}};
    assign mem_clken      = ~hold;
    assign cmd_ready      = (state_r == IDLE) && !hold;
    assign busy           = (state_r != IDLE);
    assign done           = (state_r == FIN);
    assign err            = (state_r == ERR);

endmodule

// File: doc/core6_mem_block_copier.md
# core6_mem_block_copier

Avalon-MM master that copies a contiguous block of 32-bit words from one region of a Core6 on-chip memory to another region of the same memory. Sits directly upstream of the 8192×32 single-port on-chip RAM (`s1` slave), driving its address/chipselect/write/byteenable/clken inputs and consuming its readdata. Lets a core offload buffer moves, such as message staging between cores, instead of spending CPU cycles on load/store loops.

## Interface
Parameters:
- `ADDR_W`, 13: memory word-address width (depth 2^ADDR_W = 8192 words).
- `DATA_W`, 32: memory data width. Byteenable width is DATA_W/8.

Ports:
- `clk`  in  1  single clock for the block and the attached memory.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  copy request present.
- `cmd_ready`  out  1  block can accept a request (IDLE only).
- `cmd_src`  in  ADDR_W  source start word address.
- `cmd_dst`  in  ADDR_W  destination start word address.
- `cmd_len`  in  ADDR_W+1  word count, 0..2^ADDR_W.
- `hold`  in  1  freeze request: stalls the FSM and the memory.
- `busy`  out  1  high from acceptance until `done`/`err` inclusive.
- `done`  out  1  one-cycle pulse: copy finished.
- `err`  out  1  one-cycle pulse: request rejected, no memory access made.
- `mem_address`  out  ADDR_W  memory word address.
- `mem_chipselect`  out  1  memory select.
- `mem_write`  out  1  write strobe (valid only with chipselect).
- `mem_byteenable`  out  DATA_W/8  constant all-ones.
- `mem_writedata`  out  DATA_W  write data.
- `mem_clken`  out  1  memory clock enable, equal to ~hold.
- `mem_readdata`  in  DATA_W  memory read data. Valid one cycle after the read address is presented.

## Operation
- FSM states: IDLE, RD, WR, FIN, ERR.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid` with `cmd_len` > 2^ADDR_W: go to ERR.
  - On `cmd_valid` with `cmd_len`==0: go to FIN.
  - Otherwise latch src/dst/len, clear the word counter `i`, and go to RD.
- RD: `mem_address`=src+i (mod 2^ADDR_W), chipselect=1, write=0. Next state is WR.
- WR:
  - `mem_address`=dst+i (mod 2^ADDR_W), chipselect=1, write=1, `mem_writedata`=`mem_readdata` (combinational pass-through).
  - Then i←i+1. If i+1==len go to FIN, else go to RD.
- FIN: `done`=1 for one cycle, then IDLE.
- ERR: `err`=1 for one cycle, then IDLE.
- Address arithmetic is modulo 2^ADDR_W. Copies wrap past the top word to word 0.
- Overlap: copy is strictly forward, word by word, read-before-write per index.
  - If dst lies inside (src, src+len), already-copied words are re-read. This replication is the defined behaviour.
  - dst==src is a legal no-op rewrite.
- `hold`=1: FSM state, counter and all `mem_*` outputs except `mem_clken` are frozen, and `mem_clken`=0 so the RAM output holds. `done`/`err` pulses are extended while held. `cmd_ready`=0 while `hold`=1.
- `cmd_*` inputs are ignored outside IDLE.

## Timing
- Reset values:
  - state IDLE; `cmd_ready`=1; `busy`/`done`/`err`=0.
  - `mem_chipselect`=0, `mem_write`=0, `mem_address`=0, `mem_writedata`=0.
  - `mem_byteenable`=all-ones, `mem_clken`=1 (when `hold`=0).
- Reset during any state aborts immediately: the next cycle is IDLE, with no `done`/`err` and no further memory access. A partially copied destination is left as-is.
- Accept at cycle T:
  - RD occupies T+1, WR occupies T+2, and so on; 2 cycles per word.
  - `done` is asserted at T+2N+1; `cmd_ready` is high again at T+2N+2 (N=len, no hold).
  - len==0: `done` at T+1. Rejection: `err` at T+1.
- `busy` is 0 in IDLE and 1 in every other state.
- Read latency is exactly one cycle. Write data for word i is the `mem_readdata` sampled at the WR edge.

## Test plan
- Preload words 100..103 = A,B,C,D. Command src=100, dst=200, len=4 -> words 200..203 = A,B,C,D; `done` 9 cycles after acceptance; 4 writes with byteenable 4'hF.
- Command len=0 -> `done` the next cycle, zero memory selects. Command len=8193 -> `err` the next cycle, zero memory selects.
- Wrap: src=8190, dst=10, len=4 -> words 10..13 = old 8190, 8191, 0, 1.
- Overlap: words 0..3 = A,B,C,D; src=0, dst=1, len=3 -> words 1..3 = A,A,A.
- `hold` pulsed for 5 cycles mid-copy (both during RD and during WR) -> identical memory result; `done` delayed exactly 5 cycles; `mem_clken`=0 throughout the hold.
- `reset` asserted in WR of word 2 of a len-8 copy -> IDLE next cycle; no `done`; words 0-1 written, words 3-7 untouched; a fresh command then completes normally.
